wave_capture: RTL
=================

WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 8: buffer depth is 2**ADDRESS_WIDTH samples.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: sample width.
REQ-003 The block SHALL have parameter OFFSET, default 100: second-read-port address offset, used only under REQ-027.
REQ-004 The block SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port din  input  DATA_WIDTH: sample to store.
REQ-007 The block SHALL have port din_valid  input  1: din is valid this cycle.
REQ-008 The block SHALL have port arm  input  1: single-cycle request to arm a capture.
REQ-009 The block SHALL have port trigger  input  1: capture start condition.
REQ-010 The block SHALL have port rd_addr  input  ADDRESS_WIDTH: readout address.
REQ-011 The block SHALL have port dout  output  DATA_WIDTH: registered read data at rd_addr.
REQ-012 The block SHALL have port wr_count  output  ADDRESS_WIDTH+1: samples stored in the current capture.
REQ-013 The block SHALL have port busy  output  1: high in ARMED or CAPTURE.
REQ-014 The block SHALL have port done  output  1: high in DONE.

Function
REQ-015 The FSM SHALL have states IDLE, ARMED, CAPTURE and DONE; busy and done SHALL be decoded from the state register only.
REQ-016 IDLE or DONE with arm=1 SHALL move to ARMED next cycle and clear wr_count to 0; trigger in that same cycle SHALL be ignored.
REQ-017 ARMED with trigger=1 and din_valid=1 SHALL write din to address 0, set wr_count=1 and enter CAPTURE.
REQ-018 ARMED with trigger=1 and din_valid=0 SHALL enter CAPTURE with no write; the next valid sample SHALL go to address 0.
REQ-019 In CAPTURE, each cycle with din_valid=1 SHALL write din to address wr_count[ADDRESS_WIDTH-1:0] and increment wr_count; cycles with din_valid=0 SHALL write nothing.
REQ-020 The write that makes wr_count equal 2**ADDRESS_WIDTH SHALL move the FSM to DONE next cycle; no address SHALL be written twice per capture and no wrap-around write SHALL occur.
REQ-021 arm and trigger SHALL be ignored in CAPTURE; trigger SHALL be ignored in IDLE and DONE.
REQ-022 DONE SHALL hold wr_count and buffer contents until arm or reset.
REQ-023 dout SHALL equal mem[rd_addr] sampled at the previous rising edge (1-cycle latency) in every state.
REQ-024 A read and a write to the same address in the same cycle SHALL return the old contents (read-before-write).

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, wr_count=0, dout=0, busy=0 and done=0, including mid-capture; buffer contents SHALL NOT be reset.
REQ-026 After rst_n rises, the block SHALL ignore all inputs except arm until it re-enters ARMED.

Configuration
REQ-027 With WAVE_CAPTURE_DUAL_READ_EN defined, the block SHALL add output dout2 (DATA_WIDTH), registered mem[(rd_addr+OFFSET) mod 2**ADDRESS_WIDTH] with the same latency, reset value 0 and collision rule as dout.
REQ-028 Without WAVE_CAPTURE_DUAL_READ_EN, dout2 and its storage read SHALL NOT exist, and OFFSET SHALL have no effect.

Verification (ADDRESS_WIDTH=4, DATA_WIDTH=8)
REQ-029 Bench SHALL: arm; trigger with din_valid=1 and din=0x10,0x11,...,0x1F over 16 cycles -> done=1 the cycle after the 16th write, wr_count=16, and rd_addr=5 gives dout=0x15 one cycle later.
REQ-030 Bench SHALL: din_valid toggling 1,0,1,0 during capture -> only valid samples stored at consecutive addresses; done is reached after 16 valid samples, not 16 cycles.
REQ-031 Bench SHALL: arm and trigger in the same cycle in IDLE -> FSM in ARMED, busy=1, wr_count=0, no write; a later trigger starts the capture.
REQ-032 Bench SHALL: rst_n=0 asynchronously after 7 writes -> state IDLE, busy=0, wr_count=0 and dout=0 before the next clock edge; mem[0..6] retain their values.
REQ-033 Bench SHALL: read addr 3 while writing addr 3 with 0xAA over old 0x13 -> dout=0x13 next cycle, then 0xAA the cycle after.
REQ-034 With WAVE_CAPTURE_DUAL_READ_EN and OFFSET=4, the bench SHALL set rd_addr=14 after a capture of 0x10..0x1F -> dout=0x1E and dout2=0x12.

Source files
------------

// File: rtl/wave_capture.sv
// Armed/triggered waveform capture buffer with registered, read-before-write readout.
// Optional second read port at rd_addr+OFFSET when WAVE_CAPTURE_DUAL_READ_EN is defined.
module wave_capture #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned OFFSET        = 100
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     din_valid,
  input  logic                     arm,
  input  logic                     trigger,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    dout,
`ifdef WAVE_CAPTURE_DUAL_READ_EN
  output logic [DATA_WIDTH-1:0]    dout2,
`endif
  output logic [ADDRESS_WIDTH:0]   wr_count,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
  localparam int unsigned CW    = ADDRESS_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CW-1:0]       wr_count_nxt;
  logic                wr_en_c;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // State and sample-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_count <= '0;
    end else begin
      state    <= state_nxt;
      wr_count <= wr_count_nxt;
    end
  end

  // Next-state, count and write-enable decode; the filling write ends the capture
  always_comb begin
    state_nxt    = state;
    wr_count_nxt = wr_count;
    wr_en_c      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (arm) begin
          state_nxt    = ARMED;
          wr_count_nxt = '0;
        end
      end
      ARMED: begin
        if (trigger) begin
          state_nxt = CAPTURE;
          wr_en_c   = din_valid;
        end
      end
      CAPTURE: wr_en_c = din_valid;
      default: state_nxt = IDLE;
    endcase
    if (wr_en_c) begin
      wr_count_nxt = wr_count + CW'(1);
      if (wr_count_nxt == CW'(DEPTH)) begin
        state_nxt = DONE;
      end
    end
  end

  assign busy = (state == ARMED) || (state == CAPTURE);
  assign done = (state == DONE);

  // Sample storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_count[ADDRESS_WIDTH-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else begin
      dout <= mem[rd_addr];
    end
  end

`ifdef WAVE_CAPTURE_DUAL_READ_EN
  logic [ADDRESS_WIDTH-1:0] rd_addr2_c;

  assign rd_addr2_c = rd_addr + ADDRESS_WIDTH'(OFFSET);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout2 <= '0;
    end else begin
      dout2 <= mem[rd_addr2_c];
    end
  end
`else
  // OFFSET only matters for the second read port
  logic unused_offset;
  assign unused_offset = ^OFFSET;
`endif

endmodule
